// File: rtl/cpu_ctrl_fsm_if.sv
// Control-sequencer bus: instruction ROM, register file, data memory and ALU
// hookups seen from the sequencer (master) and from the datapath (slave).
interface cpu_ctrl_fsm_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] pc;
  logic [8:0]      instr;
  logic [2:0]      alu_op;
  logic [2:0]      rd_addr;
  logic [2:0]      rs_addr;
  logic            rf_we;
  logic            wb_sel;
  logic            mem_re;
  logic            mem_we;
  logic            mem_ready;
  logic            mdr_load;
  logic            jump_flag;
  logic [7:0]      alu_out;

  modport master (
    output pc, alu_op, rd_addr, rs_addr, rf_we, wb_sel, mem_re, mem_we, mdr_load,
    input  instr, mem_ready, jump_flag, alu_out
  );

  modport slave (
    input  pc, alu_op, rd_addr, rs_addr, rf_we, wb_sel, mem_re, mem_we, mdr_load,
    output instr, mem_ready, jump_flag, alu_out
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 8-bit core: fetch, decode, execute,
// memory and write-back sequencing, branch steering, cycle/retire counters.
module cpu_ctrl_fsm #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  cpu_ctrl_fsm_if.master   bus,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [8:0] HALT_INSN = 9'h100;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD, OP_XOR, OP_AND, OP_RSL, OP_MOV, OP_LD, OP_ST, OP_BLQZ
  } op_t;

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic [8:0]      ir;
  op_t             opcode;
  logic            rf_we_q;
  logic            wb_sel_q;
  logic            mem_re_q;
  logic            mem_we_q;
  logic            retire;
  logic            counting;

  assign opcode = op_t'(ir[8:6]);

  assign bus.pc      = pc_q;
  assign bus.alu_op  = ir[8:6];
  assign bus.rd_addr = ir[5:3];
  assign bus.rs_addr = ir[2:0];
  assign bus.rf_we   = rf_we_q;
  assign bus.wb_sel  = wb_sel_q;
  assign bus.mem_re  = mem_re_q;
  assign bus.mem_we  = mem_we_q;

  // MDR must capture in the very cycle the memory completes, so this strobe
  // is decoded from registered state and the live handshake.
  assign bus.mdr_load = (state == S_MEM) && (opcode == OP_LD) && bus.mem_ready;

  // Retire points: HALT decode, BLQZ execute, ST completion, write-back.
  always_comb begin
    retire = 1'b0;
    unique case (state)
      S_DECODE: retire = (ir == HALT_INSN);
      S_EXEC:   retire = (opcode == OP_BLQZ);
      S_MEM:    retire = bus.mem_ready && (opcode == OP_ST);
      S_WB:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

  assign counting = (state != S_IDLE) && (state != S_HALT);

  // Sequencer: state, PC, IR, registered datapath enables and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc_q      <= '0;
      ir        <= '0;
      rf_we_q   <= 1'b0;
      wb_sel_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      done      <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (counting && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire && instr_cnt != '1)
        instr_cnt <= instr_cnt + CNT_W'(1);

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            pc_q      <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
          end
        end
        S_FETCH: begin
          ir    <= bus.instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (ir == HALT_INSN) begin
            state <= S_HALT;
            done  <= 1'b1;
          end else begin
            pc_q  <= pc_q + PC_W'(1);
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (opcode)
            OP_LD: begin
              mem_re_q <= 1'b1;
              state    <= S_MEM;
            end
            OP_ST: begin
              mem_we_q <= 1'b1;
              state    <= S_MEM;
            end
            OP_BLQZ: begin
              if (bus.jump_flag)
                pc_q <= PC_W'(bus.alu_out);
              state <= S_FETCH;
            end
            default: begin
              rf_we_q  <= 1'b1;
              wb_sel_q <= 1'b0;
              state    <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (opcode == OP_LD) begin
              rf_we_q  <= 1'b1;
              wb_sel_q <= 1'b1;
              state    <= S_WB;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          rf_we_q  <= 1'b0;
          wb_sel_q <= 1'b0;
          state    <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            state     <= S_FETCH;
            pc_q      <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            done      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: directed vector table, hand-written corner
// sequences and random forward-branching programs against an
// instruction-level reference model.
module tb_cpu_ctrl_fsm;
  localparam int PC_W  = 8;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [8:0] HALT_W = 9'h100;
  localparam logic [8:0] BLQZ_W = 9'h1C0;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  cpu_ctrl_fsm_if #(.PC_W(PC_W)) bus ();

  cpu_ctrl_fsm #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .done      (done),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  // Environment: ROM, ALU branch decision and memory latency, all keyed by
  // the address of the instruction in flight (pc has already advanced).
  logic [8:0]  rom     [256];
  logic        jf_tab  [256];
  logic [7:0]  tgt_tab [256];
  int unsigned lat_tab [256];
  logic        mem_block = 1'b0;
  int unsigned wcnt;
  logic [7:0]  prev_pc;

  // ROM, ALU and memory responses
  always_comb begin
    prev_pc       = bus.pc - 8'd1;
    bus.instr     = rom[bus.pc];
    bus.jump_flag = jf_tab[prev_pc];
    bus.alu_out   = tgt_tab[prev_pc];
    bus.mem_ready = !mem_block && (bus.mem_re || bus.mem_we) &&
                    (wcnt + 1 >= lat_tab[prev_pc]);
  end

  // Memory wait counter
  always_ff @(posedge clk) begin
    if (reset || !(bus.mem_re || bus.mem_we) || bus.mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic clear_env();
    for (int i = 0; i < 256; i++) begin
      rom[i]     = HALT_W;
      jf_tab[i]  = 1'b0;
      tgt_tab[i] = 8'h00;
      lat_tab[i] = 1;
    end
  endtask

  // Run observations
  int n_rfwe, n_wbsel, n_req, n_mdr, done_cyc, first_rfwe_cyc, first_rfwe_op, mdr_cyc, halt_pc;
  int exp_wr[$];

  task automatic run_prog(input bit patch0, input bit hold, input bit chk_wr);
    int cyc;
    n_rfwe = 0; n_wbsel = 0; n_req = 0; n_mdr = 0;
    done_cyc = -1; first_rfwe_cyc = -1; first_rfwe_op = -1; mdr_cyc = -1; halt_pc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0;
    cyc = 1;
    while (cyc <= 600) begin
      if (bus.rf_we) begin
        n_rfwe++;
        if (first_rfwe_cyc < 0) begin
          first_rfwe_cyc = cyc;
          first_rfwe_op  = int'(bus.alu_op);
        end
        if (bus.wb_sel) n_wbsel++;
        if (chk_wr && exp_wr.size() > 0)
          check("wr_op_rd", int'({bus.alu_op, bus.rd_addr}), exp_wr.pop_front());
      end
      if (bus.mem_re || bus.mem_we) n_req++;
      if (bus.mdr_load) begin
        n_mdr++;
        if (mdr_cyc < 0) mdr_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        halt_pc  = int'(bus.pc);
        break;
      end
      if (patch0 && cyc == 2) rom[0] = HALT_W;
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    check("done_seen", int'(done_cyc > 0), 1);
  endtask

  // Instruction-level reference: walks the program and sums per-instruction costs.
  task automatic model(output int m_cyc, output int m_ret, output int m_rfwe,
                       output int m_wbs, output int m_req, output int m_ld,
                       output int m_hpc);
    logic [7:0] p;
    logic [8:0] w;
    logic [2:0] op;
    logic [2:0] rd;
    p = 8'h00;
    m_cyc = 0; m_ret = 0; m_rfwe = 0; m_wbs = 0; m_req = 0; m_ld = 0; m_hpc = -1;
    exp_wr.delete();
    for (int step = 0; step < 300; step++) begin
      w = rom[p];
      if (w == HALT_W) begin
        m_cyc += 2; m_ret++; m_hpc = int'(p);
        break;
      end
      op = w[8:6];
      rd = w[5:3];
      m_ret++;
      if (op == 3'd7) begin
        m_cyc += 3;
        p = jf_tab[p] ? tgt_tab[p] : p + 8'd1;
      end else if (op == 3'd6) begin
        m_cyc += 3 + int'(lat_tab[p]);
        m_req += int'(lat_tab[p]);
        p = p + 8'd1;
      end else begin
        if (op == 3'd5) begin
          m_cyc += 4 + int'(lat_tab[p]);
          m_req += int'(lat_tab[p]);
          m_wbs++; m_ld++;
        end else begin
          m_cyc += 4;
        end
        m_rfwe++;
        exp_wr.push_back(int'({op, rd}));
        p = p + 8'd1;
      end
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [8:0] ins;
    int         lat;
    logic       jf;
    logic [7:0] tgt;
    int         cyc;
    int         hpc;
    int         rfwe;
    int         wbsel;
    int         req;
    int         mdrc;
  } vec_t;

  initial begin
    vec_t vt [13];
    int m_cyc, m_ret, m_rfwe, m_wbs, m_req, m_ld, m_hpc;
    int k;

    vt[0]  = '{8'h00, 9'h00A, 1, 1'b0, 8'h00, 4, 1,  1, 0, 0, -1};
    vt[1]  = '{8'h00, 9'h05C, 1, 1'b0, 8'h00, 4, 1,  1, 0, 0, -1};
    vt[2]  = '{8'h00, 9'h0BF, 1, 1'b0, 8'h00, 4, 1,  1, 0, 0, -1};
    vt[3]  = '{8'h00, 9'h0C1, 1, 1'b0, 8'h00, 4, 1,  1, 0, 0, -1};
    vt[4]  = '{8'h00, 9'h108, 1, 1'b0, 8'h00, 4, 1,  1, 0, 0, -1};
    vt[5]  = '{8'h00, 9'h151, 3, 1'b0, 8'h00, 7, 1,  1, 1, 3,  6};
    vt[6]  = '{8'h00, 9'h151, 1, 1'b0, 8'h00, 5, 1,  1, 1, 1,  4};
    vt[7]  = '{8'h00, 9'h18A, 2, 1'b0, 8'h00, 5, 1,  0, 0, 2, -1};
    vt[8]  = '{8'h00, 9'h18A, 1, 1'b0, 8'h00, 4, 1,  0, 0, 1, -1};
    vt[9]  = '{8'h05, 9'h1C0, 1, 1'b1, 8'h20, 3, 32, 0, 0, 0, -1};
    vt[10] = '{8'h05, 9'h1C0, 1, 1'b0, 8'h20, 3, 6,  0, 0, 0, -1};
    vt[11] = '{8'hFF, 9'h1C0, 1, 1'b0, 8'h20, 3, 0,  0, 0, 0, -1};
    vt[12] = '{8'h05, 9'h151, 2, 1'b0, 8'h00, 6, 6,  1, 1, 2,  8};

    clear_env();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state held through 10 idle cycles
    repeat (10) @(negedge clk);
    check("rst_pc", int'(bus.pc), 0);
    check("rst_alu_op", int'(bus.alu_op), 0);
    check("rst_rd", int'(bus.rd_addr), 0);
    check("rst_rs", int'(bus.rs_addr), 0);
    check("rst_rf_we", int'(bus.rf_we), 0);
    check("rst_wb_sel", int'(bus.wb_sel), 0);
    check("rst_mem_re", int'(bus.mem_re), 0);
    check("rst_mem_we", int'(bus.mem_we), 0);
    check("rst_mdr_load", int'(bus.mdr_load), 0);
    check("rst_done", int'(done), 0);
    check("rst_cycle_cnt", int'(cycle_cnt), 0);
    check("rst_instr_cnt", int'(instr_cnt), 0);

    // ADD r1,r2 then HALT
    clear_env();
    rom[0] = 9'h00A;
    exp_wr.delete();
    exp_wr.push_back(1);
    run_prog(1'b0, 1'b0, 1'b1);
    check("add_rfwe_cycle", first_rfwe_cyc, 4);
    check("add_rfwe_op", first_rfwe_op, 0);
    check("add_rfwe_count", n_rfwe, 1);
    check("add_wr_left", exp_wr.size(), 0);
    check("add_done_cycle", done_cyc, 7);
    check("add_instr_cnt", int'(instr_cnt), 2);
    check("add_cycle_cnt", int'(cycle_cnt), 6);

    // Same program with start held high throughout: must be ignored mid-run
    run_prog(1'b0, 1'b1, 1'b0);
    check("hold_done_cycle", done_cyc, 7);
    check("hold_cycle_cnt", int'(cycle_cnt), 6);
    check("hold_instr_cnt", int'(instr_cnt), 2);

    // Directed single-instruction vectors
    for (int i = 0; i < 13; i++) begin
      int pre;
      clear_env();
      pre = (vt[i].addr != 8'h00) ? 1 : 0;
      if (pre != 0) begin
        rom[0]     = BLQZ_W;
        jf_tab[0]  = 1'b1;
        tgt_tab[0] = vt[i].addr;
      end
      rom[vt[i].addr]     = vt[i].ins;
      lat_tab[vt[i].addr] = vt[i].lat;
      jf_tab[vt[i].addr]  = vt[i].jf;
      tgt_tab[vt[i].addr] = vt[i].tgt;
      run_prog(pre != 0, 1'b0, 1'b0);
      check($sformatf("v%0d_done_cycle", i), done_cyc, 3 * pre + vt[i].cyc + 3);
      check($sformatf("v%0d_halt_pc", i), halt_pc, vt[i].hpc);
      check($sformatf("v%0d_rf_we", i), n_rfwe, vt[i].rfwe);
      check($sformatf("v%0d_wb_sel", i), n_wbsel, vt[i].wbsel);
      check($sformatf("v%0d_mem_req", i), n_req, vt[i].req);
      check($sformatf("v%0d_mdr_cycle", i), mdr_cyc, vt[i].mdrc);
      check($sformatf("v%0d_cycle_cnt", i), int'(cycle_cnt), 3 * pre + vt[i].cyc + 2);
      check($sformatf("v%0d_instr_cnt", i), int'(instr_cnt), pre + 2);
    end

    // Both counters saturate: 70 ADDs + HALT
    clear_env();
    for (int a = 0; a < 70; a++) rom[a] = 9'h00A;
    run_prog(1'b0, 1'b0, 1'b0);
    check("sat_done_cycle", done_cyc, 70 * 4 + 3);
    check("sat_cycle_cnt", int'(cycle_cnt), CMAX);
    check("sat_instr_cnt", int'(instr_cnt), CMAX);

    // Random forward-branching programs
    for (int it = 0; it < 40; it++) begin
      int len;
      logic [8:0] w;
      clear_env();
      len = $urandom_range(14, 3);
      for (int a = 0; a < len; a++) begin
        w = 9'($urandom_range(511, 0));
        if (w == HALT_W) w = 9'h101;
        rom[a]     = w;
        lat_tab[a] = $urandom_range(4, 1);
        jf_tab[a]  = 1'($urandom_range(1, 0));
        tgt_tab[a] = 8'($urandom_range(len, a + 1));
      end
      model(m_cyc, m_ret, m_rfwe, m_wbs, m_req, m_ld, m_hpc);
      run_prog(1'b0, 1'b0, 1'b1);
      check($sformatf("r%0d_done_cycle", it), done_cyc, m_cyc + 1);
      check($sformatf("r%0d_cycle_cnt", it), int'(cycle_cnt), (m_cyc > CMAX) ? CMAX : m_cyc);
      check($sformatf("r%0d_instr_cnt", it), int'(instr_cnt), (m_ret > CMAX) ? CMAX : m_ret);
      check($sformatf("r%0d_halt_pc", it), halt_pc, m_hpc);
      check($sformatf("r%0d_rf_we", it), n_rfwe, m_rfwe);
      check($sformatf("r%0d_wb_sel", it), n_wbsel, m_wbs);
      check($sformatf("r%0d_mem_req", it), n_req, m_req);
      check($sformatf("r%0d_mdr_load", it), n_mdr, m_ld);
      check($sformatf("r%0d_wr_left", it), exp_wr.size(), 0);
    end

    // Reset while ST waits in MEM
    clear_env();
    rom[0] = 9'h18A;
    mem_block = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!bus.mem_we && k < 10) begin
      @(negedge clk); k++;
    end
    check("st_mem_we_seen", int'(bus.mem_we), 1);
    @(negedge clk);
    check("st_mem_we_held", int'(bus.mem_we), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("st_rst_mem_we", int'(bus.mem_we), 0);
    check("st_rst_instr_cnt", int'(instr_cnt), 0);
    check("st_rst_pc", int'(bus.pc), 0);
    repeat (3) @(negedge clk);
    check("st_rst_idle_cycle_cnt", int'(cycle_cnt), 0);
    check("st_rst_idle_mem_we", int'(bus.mem_we), 0);
    mem_block = 1'b0;

    // Reset and start in the same cycle: reset wins, no execution begins
    clear_env();
    rom[0] = 9'h00A;
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rs_cycle_cnt", int'(cycle_cnt), 0);
    check("rs_pc", int'(bus.pc), 0);
    check("rs_rf_we", int'(bus.rf_we), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control sequencer for the 8-bit core: fetches 9-bit instructions, decodes them into the 3-bit ALU opcode and datapath enables, and consumes the ALU's `jumpFlag` and result to steer the PC. It sits between instruction ROM, register file, data memory and the ALU. It is the producer of `aluOp` and the consumer of the branch decision. It also keeps cycle and retired-instruction counters for the bench.

## Interface
- PC_W, 8, program counter width
- CNT_W, 16, width of the performance counters

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin execution at PC 0 (pulse)
- pc  out  PC_W  instruction ROM address
- instr  in  9  ROM data for `pc`, combinational, valid same cycle
- alu_op  out  3  to ALU: ADD=0 XOR=1 AND=2 RSL=3 MOV=4 LD=5 ST=6 BLQZ=7
- rd_addr  out  3  register-file read/write port A, IR[5:3]
- rs_addr  out  3  register-file read port B, IR[2:0]
- rf_we  out  1  register-file write enable
- wb_sel  out  1  0 = ALU result, 1 = MDR
- mem_re  out  1  data-memory read request
- mem_we  out  1  data-memory write request
- mem_ready  in  1  data-memory completion handshake
- mdr_load  out  1  datapath latches memory read data into MDR
- jump_flag  in  1  from ALU, valid in EXEC
- alu_out  in  8  from ALU, branch target in EXEC
- done  out  1  program halted
- cycle_cnt  out  CNT_W  cycles since start, saturating
- instr_cnt  out  CNT_W  instructions retired, saturating

## Operation
- IR[8:6] = opcode = alu_op. Encoding 9'h100 (MOV r0,r0) is HALT.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE:
  - `start` → FETCH, with pc=0 and both counters cleared.
  - Otherwise stay in IDLE.
- FETCH: IR ← instr → DECODE.
- DECODE:
  - If IR == HALT → HALT.
  - Otherwise pc ← pc+1, wrapping 2^PC_W−1 → 0, then → EXEC.
  - The HALT instruction does not advance pc.
- EXEC: alu_op = IR[8:6]. Next state by opcode:
  - ADD/XOR/AND/RSL/MOV → WB.
  - LD/ST → MEM.
  - BLQZ: if jump_flag=1, pc ← alu_out (overrides the DECODE increment). Retire, then → FETCH.
- MEM:
  - LD: mem_re=1; ST: mem_we=1.
  - Requests are held at 1 until the cycle mem_ready=1; there is no timeout.
  - LD with mem_ready → mdr_load=1 → WB.
  - ST with mem_ready → retire → FETCH.
- WB:
  - rf_we=1 for exactly one cycle.
  - wb_sel=1 for LD, 0 otherwise.
  - Retire → FETCH.
- HALT:
  - done=1; the instruction is retired once.
  - Stay until `start`, which → FETCH with pc=0, counters cleared and done=0.
- alu_op, rd_addr and rs_addr always reflect IR. rf_we, mem_re, mem_we and mdr_load are 0 outside the states above.
- cycle_cnt increments every cycle outside IDLE/HALT. instr_cnt increments on each retire. Both saturate at all-ones.
- `start` outside IDLE/HALT is ignored.

## Timing
- Reset (synchronous, wins over everything):
  - state=IDLE, pc=0, IR=0, so alu_op=0, rd_addr=0, rs_addr=0.
  - All enables 0, done=0, cycle_cnt=0, instr_cnt=0.
- Latency from `start` high to the first FETCH: 1 cycle.
- Cycles per instruction:
  - ALU ops: 4 (FETCH, DECODE, EXEC, WB).
  - BLQZ: 3.
  - ST: 3 + N.
  - LD: 4 + N.
  - N = MEM cycles, ≥ 1; mem_ready high on MEM entry gives N=1.
- Branch: taken target appears on pc in the cycle after EXEC, i.e. the following FETCH.
- Reset mid-MEM: mem_re/mem_we drop in the cycle after reset is sampled. No partial retire is counted.
- reset and start asserted in the same cycle: reset wins.
- Counter saturation: at all-ones, further events hold the value and do not wrap.

## Test plan
- Reset, then no start for 10 cycles → pc=0, state IDLE, all enables 0, counters 0.
- start; ROM[0]=ADD r1,r2 (9'h00A), ROM[1]=HALT:
  - rf_we pulses exactly once, at cycle 4, with alu_op=0.
  - done=1 at cycle 7.
  - instr_cnt=2, cycle_cnt=6.
- LD with mem_ready delayed 3 cycles:
  - mem_re held for 3 cycles.
  - mdr_load=1 in the third MEM cycle, then rf_we=1 with wb_sel=1.
  - Instruction takes 7 cycles.
- BLQZ at pc=5:
  - jump_flag=1, alu_out=8'h20 → next fetch pc=8'h20.
  - jump_flag=0 → next fetch pc=6.
  - Both take 3 cycles.
- BLQZ at pc=8'hFF with jump_flag=0 → pc wraps to 0.
- ST in MEM with mem_ready=0, reset asserted → mem_we=0 next cycle, state IDLE, instr_cnt unchanged (0).
